// File: rtl/acumulador_s_pkg.sv
// Shared types and defaults for the acumulador_s batch accumulator.
package acumulador_s_pkg;

    // Controller states: waiting for the first sample, mid-batch, batch ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_ACC_WIDTH = 16;
    localparam int DEF_NUM_OPS   = 4;

    // Width needed to hold a sample count from 0 up to and including NUM_OPS
    function automatic int count_w(input int num_ops);
        return $clog2(num_ops + 1);
    endfunction

endpackage

// File: rtl/acumulador_s_contador_lote.sv
// contador_lote: counts samples accepted in the current batch and flags the
// accept that completes the batch.
module contador_lote
    import acumulador_s_pkg::*;
#(
    parameter int NUM_OPS = DEF_NUM_OPS,
    parameter int CW      = count_w(DEF_NUM_OPS)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_inc,
    input  logic          i_clr,
    output logic [CW-1:0] o_count,
    output logic          o_last
);

    logic [CW-1:0] r_count;

    // Sample counter; clear wins over increment
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_count = r_count;
    assign o_last  = i_inc && (r_count == CW'(NUM_OPS - 1));

endmodule

// File: rtl/acumulador_s.sv
// acumulador_s: accepts {cout, s} results from the adder stage, sums a batch
// of NUM_OPS of them and presents the total, count and overflow flag.
// Optional build macro: ACUMULADOR_S_SAT_EN (saturate instead of wrapping).
module acumulador_s
    import acumulador_s_pkg::*;
#(
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter  int NUM_OPS   = DEF_NUM_OPS,
    localparam int CW        = count_w(NUM_OPS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [WIDTH-1:0]     i_s,
    input  logic                 i_cout,
    input  logic                 i_clear,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [ACC_WIDTH-1:0] o_acc,
    output logic [CW-1:0]        o_count,
    output logic                 o_ovf
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic                   r_ovf;
    logic                   w_accept;
    logic                   w_release;
    logic                   w_last;
    logic [ACC_WIDTH:0]     w_value;
    logic [ACC_WIDTH:0]     w_sum;
    logic                   w_carry;
    logic [ACC_WIDTH-1:0]   w_acc_next;

    assign o_in_ready  = (r_state != HOLD);
    assign o_out_valid = (r_state == HOLD);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_release   = o_out_valid && i_out_ready;

    assign w_value = {{(ACC_WIDTH - WIDTH){1'b0}}, i_cout, i_s};
    assign w_sum   = {1'b0, r_acc} + w_value;
    assign w_carry = w_sum[ACC_WIDTH];

    contador_lote #(
        .NUM_OPS (NUM_OPS),
        .CW      (CW)
    ) u_contador_lote (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_accept && !i_clear),
        .i_clr   (i_clear || w_release),
        .o_count (o_count),
        .o_last  (w_last)
    );

    // Next total after an accept: wrap by default, pin to all-ones if saturating
    always_comb begin
        w_acc_next = w_sum[ACC_WIDTH-1:0];
`ifdef ACUMULADOR_S_SAT_EN
        if (w_carry) begin
            w_acc_next = '1;
        end
`endif
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; clear overrides any handshake in flight
    always_comb begin
        w_next_state = r_state;
        if (i_clear) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        w_next_state = w_last ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (i_out_ready) begin
                        w_next_state = IDLE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Running total and sticky overflow, cleared on clear or batch hand-off
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_clear || w_release) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_ovf <= r_ovf | w_carry;
        end
    end

    assign o_acc = r_acc;
    assign o_ovf = r_ovf;

endmodule
